// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider on one
// shared 2*WIDTH-bit accumulator, fixed WIDTH+2 cycle latency per request.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_err
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    state_t               state_r, state_s;
    logic [2:0]           op_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [2*WIDTH-1:0]   acc_r, step_s;
    logic [CW-1:0]        count_r;
    logic                 neg_q_r, neg_r_r;
    logic                 in_ready_r, out_valid_r, out_err_r;
    logic [WIDTH-1:0]     out_r, result_s, mag_a_s, mag_b_s, quot_s, rem_s;
    logic [WIDTH:0]       mul_sum_s, div_trial_s;
    logic                 accept_s, signed_s, div0_s, err_s;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? negate(x) : x;
    endfunction

    assign accept_s    = in_valid && in_ready_r;
    assign signed_s    = (MDOp == 3'd4) || (MDOp == 3'd5);
    assign mag_a_s     = signed_s ? magnitude(in1) : in1;
    assign mag_b_s     = signed_s ? magnitude(in2) : in2;
    // Multiplier bits are consumed from acc_r[0]; the divider shifts the next dividend bit into the remainder.
    assign mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    assign div_trial_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_r};
    assign quot_s      = acc_r[WIDTH-1:0];
    assign rem_s       = acc_r[2*WIDTH-1:WIDTH];
    assign div0_s      = (opnd_r == ZERO);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (accept_s) state_s = CALC; else state_s = IDLE;
            CALC:    if (count_r == CW'(WIDTH - 1)) state_s = FIX; else state_s = CALC;
            FIX:     state_s = DONE;
            DONE:    if (out_ready) state_s = IDLE; else state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // One multiply or divide iteration.
    always_comb begin
        step_s = acc_r;
        if (op_r <= 3'd1) begin
            step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end else if (!div_trial_s[WIDTH]) begin
            step_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            step_s = {acc_r[2*WIDTH-2:0], 1'b0};
        end
    end

    // Result selection with sign correction; signed overflow falls out of the magnitude path.
    always_comb begin
        result_s = ZERO;
        err_s    = 1'b0;
        case (op_r)
            3'd0:    result_s = quot_s;
            3'd1:    result_s = rem_s;
            3'd2:    if (div0_s) result_s = ONES; else result_s = quot_s;
            3'd3:    result_s = rem_s;
            3'd4:    if (div0_s) result_s = ONES; else if (neg_q_r) result_s = negate(quot_s); else result_s = quot_s;
            3'd5:    if (neg_r_r) result_s = negate(rem_s); else result_s = rem_s;
            default: begin
                result_s = ZERO;
                err_s    = 1'b1;
            end
        endcase
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r    <= 3'd0;
            opnd_r  <= ZERO;
            acc_r   <= {(2*WIDTH){1'b0}};
            count_r <= {CW{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (state_r == IDLE && accept_s) begin
            op_r    <= MDOp;
            count_r <= {CW{1'b0}};
            neg_q_r <= signed_s && (in1[WIDTH-1] ^ in2[WIDTH-1]);
            neg_r_r <= signed_s && in1[WIDTH-1];
            if (MDOp <= 3'd1) begin
                acc_r  <= {ZERO, in2};
                opnd_r <= in1;
            end else begin
                acc_r  <= {ZERO, mag_a_s};
                opnd_r <= mag_b_s;
            end
        end else if (state_r == CALC) begin
            acc_r   <= step_s;
            count_r <= count_r + CW'(1);
        end
    end

    // Registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_r       <= ZERO;
            out_err_r   <= 1'b0;
        end else begin
            in_ready_r <= (state_r == IDLE) && (state_s == IDLE);
            if (state_r == FIX) begin
                out_r       <= result_s;
                out_err_r   <= err_s;
                out_valid_r <= 1'b1;
            end else if (state_r == DONE && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign out_err   = out_err_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: literal expectations per request plus a
// transaction-level model checked on every cycle after reset.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   MDOp = 3'd0;
    logic [W-1:0] in1 = 32'd0;
    logic [W-1:0] in2 = 32'd0;
    logic         in_ready, out_valid, out_err;
    logic [W-1:0] out;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .MDOp(MDOp),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa, sb;
        logic [31:0]        r;
        logic               e;
        p  = {32'd0, a} * {32'd0, b};
        sa = a;
        sb = b;
        r  = 32'd0;
        e  = 1'b0;
        case (op)
            3'd0: r = p[31:0];
            3'd1: r = p[63:32];
            3'd2: if (b == 32'd0) r = 32'hFFFF_FFFF; else r = a / b;
            3'd3: if (b == 32'd0) r = a; else r = a % b;
            3'd4: if (b == 32'd0) r = 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                  else r = sa / sb;
            3'd5: if (b == 32'd0) r = a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                  else r = sa % sb;
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    // Model state: one request in flight, result due a fixed number of cycles after accept.
    logic        mon_on = 1'b0;
    logic        busy = 1'b0;
    logic        hs_last = 1'b0;
    int          due = 0;
    logic [31:0] exp_out = 32'd0;
    logic        exp_err = 1'b0;

    always @(negedge clk) begin
        logic        exp_ov, exp_ir;
        logic [32:0] m;
        if (mon_on) begin
            exp_ov = busy && (cyc >= due);
            exp_ir = !busy && !hs_last;
            chk1("out_valid", out_valid, exp_ov);
            chk1("in_ready", in_ready, exp_ir);
            if (exp_ov) begin
                chk32("out", out, exp_out);
                chk1("out_err", out_err, exp_err);
            end
            if (rst) begin
                busy    = 1'b0;
                hs_last = 1'b0;
            end else if (exp_ov && out_ready) begin
                busy    = 1'b0;
                hs_last = 1'b1;
            end else begin
                hs_last = 1'b0;
                if (exp_ir && in_valid) begin
                    m       = model(MDOp, in1, in2);
                    busy    = 1'b1;
                    due     = cyc + 34;
                    exp_out = m[31:0];
                    exp_err = m[32];
                end
            end
        end
    end

    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        MDOp     = op;
        in1      = a;
        in2      = b;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        chk1("accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        MDOp     = 3'($urandom_range(0, 7));
        in1      = $urandom;
        in2      = $urandom;
    endtask

    task automatic wait_result(input string name, input logic lit, input logic [31:0] exp_o, input logic exp_e);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 80);
        chk32({name, "_latency"}, 32'(lat), 32'd33);
        if (lit) begin
            chk32({name, "_out"}, out, exp_o);
            chk1({name, "_err"}, out_err, exp_e);
        end
    endtask

    task automatic release_out(input int hold);
        repeat (hold) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_o, input logic exp_e);
        start(op, a, b);
        wait_result(name, 1'b1, exp_o, exp_e);
        release_out(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk32("rst_out", out, 32'd0);
        chk1("rst_out_err", out_err, 1'b0);

        run("mul_7x6",    3'd0, 32'd7,          32'd6,          32'h0000_002A, 1'b0);
        run("mulhu_max",  3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 1'b0);
        run("divu_100_7", 3'd2, 32'd100,        32'd7,          32'd14,        1'b0);
        run("remu_100_7", 3'd3, 32'd100,        32'd7,          32'd2,         1'b0);
        run("div_m7_2",   3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 1'b0);
        run("rem_m7_2",   3'd5, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 1'b0);
        run("divu_by0",   3'd2, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b0);
        run("rem_by0",    3'd5, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB, 1'b0);
        run("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b0);
        run("rem_ovf",    3'd5, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1'b0);
        run("illegal6",   3'd6, 32'd9,          32'd3,          32'd0,         1'b1);
        run("mul_2x3",    3'd0, 32'd2,          32'd3,          32'd6,         1'b0);
        run("illegal7",   3'd7, 32'd1,          32'd1,          32'd0,         1'b1);
        run("div_m100_7", 3'd4, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2, 1'b0);

        // Random operands, checked by the model only.
        for (int i = 0; i < 6; i++) begin
            start(3'(i), $urandom, (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            wait_result("rand", 1'b0, 32'd0, 1'b0);
            release_out(1 + i);
        end

        // Backpressure with a request held on the input side.
        start(3'd2, 32'd1000, 32'd10);
        wait_result("bp_divu", 1'b1, 32'd100, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        MDOp     = 3'd3;
        in1      = 32'd1000;
        in2      = 32'd9;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk32("bp_out_hold", out, 32'd100);
        chk1("bp_valid_hold", out_valid, 1'b1);
        chk1("bp_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 10);
        chk32("ready_gap", 32'(n), 32'd2);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result("held_remu", 1'b1, 32'd1, 1'b0);
        release_out(1);

        // Reset on the tenth edge after accept discards the operation.
        start(3'd2, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk32("midrst_out", out, 32'd0);
        repeat (40) @(posedge clk);
        run("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
